// File: rtl/shift_code_scroller.sv
// Programmable code buffer with a NUM_DIGITS-wide window that scrolls around it,
// stepped by an internal tick divider (run=1) or by manual step pulses (run=0).
module shift_code_scroller #(
    parameter int NUM_DIGITS = 8,
    parameter int MAX_LEN    = 16,
    parameter int DIG_W      = 4,
    parameter int TICK_DIV   = 50_000_000,
    localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1,
    localparam int LW = $clog2(MAX_LEN + 1),
    localparam int TW = $clog2(TICK_DIV)
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        wr_en,
    input  logic [AW-1:0]               wr_addr,
    input  logic [DIG_W-1:0]            wr_data,
    input  logic [LW-1:0]               len,
    input  logic                        run,
    input  logic                        dir,
    input  logic                        step_req,
    output logic [NUM_DIGITS*DIG_W-1:0] digits_o,
    output logic [AW-1:0]               pos_o,
    output logic                        step_o
);

    logic [DIG_W-1:0]            code [MAX_LEN];
    logic [TW-1:0]               tcnt;

    logic [LW-1:0]               eff_len;
    logic [LW-1:0]               pos_ext;
    logic [LW-1:0]               pos_nxt;
    logic                        tick_wrap;
    logic                        step_evt;
    logic [AW-1:0]               pos_inc;
    logic [AW-1:0]               pos_dec;

    logic [AW-1:0]               start_idx;
    logic [AW-1:0]               cur_idx;
    logic [LW-1:0]               cur_nxt;
    logic [NUM_DIGITS*DIG_W-1:0] window;

    always_comb begin
        eff_len   = (int'(len) > MAX_LEN) ? LW'(MAX_LEN) : len;
        pos_ext   = LW'(pos_o);
        pos_nxt   = pos_ext + LW'(1);
        tick_wrap = run && (tcnt == TW'(TICK_DIV - 1));
        step_evt  = tick_wrap || (!run && step_req);
        pos_inc   = (pos_nxt == eff_len) ? '0 : AW'(pos_nxt);
        pos_dec   = (pos_o == '0) ? AW'(eff_len - LW'(1)) : pos_o - AW'(1);
    end

    // Only the window start needs a true modulo (pos can briefly exceed a shortened
    // length); later digits follow with a cheap increment-and-wrap chain.
    always_comb begin
        window    = '0;
        cur_nxt   = '0;
        start_idx = (eff_len == '0) ? '0 : AW'(pos_ext % eff_len);
        cur_idx   = start_idx;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (eff_len != '0) begin
                window[(NUM_DIGITS-k)*DIG_W-1 -: DIG_W] = code[cur_idx];
            end
            cur_nxt = LW'(cur_idx) + LW'(1);
            cur_idx = (cur_nxt == eff_len) ? '0 : AW'(cur_nxt);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MAX_LEN; i++) begin
                code[i] <= '0;
            end
            tcnt     <= '0;
            pos_o    <= '0;
            step_o   <= 1'b0;
            digits_o <= '0;
        end else begin
            if (wr_en && (int'(wr_addr) < MAX_LEN)) begin
                code[wr_addr] <= wr_data;
            end
            if (run) begin
                tcnt <= tick_wrap ? '0 : tcnt + TW'(1);
            end
            step_o <= 1'b0;
            // An out-of-range position is repaired first; a coincident step is dropped.
            if ((eff_len == '0) || (pos_ext >= eff_len)) begin
                pos_o <= '0;
            end else if (step_evt) begin
                pos_o  <= dir ? pos_dec : pos_inc;
                step_o <= 1'b1;
            end
            digits_o <= window;
        end
    end

endmodule

// File: tb/tb_shift_code_scroller.sv
// Scoreboard bench for shift_code_scroller: the driver pushes expected outputs from
// an arithmetic reference model, and a monitor compares them one cycle later.
module tb_shift_code_scroller;

    localparam int ND = 8;
    localparam int ML = 10;
    localparam int DW = 4;
    localparam int TD = 4;

    logic        clk      = 1'b0;
    logic        rst_n    = 1'b1;
    logic        wr_en    = 1'b0;
    logic [3:0]  wr_addr  = '0;
    logic [3:0]  wr_data  = '0;
    logic [3:0]  len      = '0;
    logic        run      = 1'b0;
    logic        dir      = 1'b0;
    logic        step_req = 1'b0;
    logic [31:0] digits_o;
    logic [3:0]  pos_o;
    logic        step_o;

    typedef struct {
        int          pos;
        bit          step;
        logic [31:0] dig;
    } exp_t;

    exp_t sb[$];
    int   code_m[ML];
    int   pos_m;
    int   tcnt_m;
    int   checks;
    int   errors;
    int   load_code[ML] = '{2, 0, 1, 1, 0, 4, 5, 6, 7, 8};

    shift_code_scroller #(
        .NUM_DIGITS(ND),
        .MAX_LEN   (ML),
        .DIG_W     (DW),
        .TICK_DIV  (TD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .len      (len),
        .run      (run),
        .dir      (dir),
        .step_req (step_req),
        .digits_o (digits_o),
        .pos_o    (pos_o),
        .step_o   (step_o)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model_window(input int l);
        logic [31:0] w;
        w = '0;
        if (l > 0) begin
            for (int k = 0; k < ND; k++) begin
                w[(ND-k)*DW-1 -: DW] = 4'(code_m[(pos_m + k) % l]);
            end
        end
        return w;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ML; i++) code_m[i] = 0;
        pos_m  = 0;
        tcnt_m = 0;
    endtask

    // One clock cycle of stimulus; the reference model advances and queues its prediction.
    task automatic apply_stimulus(input bit we, input int wa, input int wd, input int ln,
                                  input bit r, input bit d, input bit sr);
        exp_t e;
        int   l;
        bit   evt;
        @(negedge clk);
        rst_n    = 1'b1;
        wr_en    = we;
        wr_addr  = 4'(wa);
        wr_data  = 4'(wd);
        len      = 4'(ln);
        run      = r;
        dir      = d;
        step_req = sr;
        l        = (ln > ML) ? ML : ln;
        e.dig    = model_window(l);
        evt      = (r && tcnt_m == TD - 1) || (!r && sr);
        if (r) tcnt_m = (tcnt_m + 1) % TD;
        if (we && wa < ML) code_m[wa] = wd;
        e.step = 1'b0;
        if (l == 0 || pos_m >= l) begin
            pos_m = 0;
        end else if (evt) begin
            pos_m  = d ? (pos_m + l - 1) % l : (pos_m + 1) % l;
            e.step = 1'b1;
        end
        e.pos = pos_m;
        sb.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        sb.delete();
        model_reset();
        #1;
        check_output("reset_digits", digits_o, 32'h0);
        check_output("reset_pos", 32'(pos_o), 32'h0);
        check_output("reset_step", 32'(step_o), 32'h0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n && sb.size() > 0) begin
                e = sb.pop_front();
                check_output("pos", 32'(pos_o), 32'(e.pos));
                check_output("step", 32'(step_o), 32'(e.step));
                check_output("digits", digits_o, e.dig);
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] timeout");
    end

    initial begin : driver
        bit cur_run;
        int cur_len;
        int first_step;
        checks = 0;
        errors = 0;
        model_reset();
        #2;
        rst_n = 1'b0;
        do_reset();

        for (int i = 0; i < ML; i++) apply_stimulus(1, i, load_code[i], 10, 0, 0, 0);
        repeat (2) apply_stimulus(0, 0, 0, 10, 0, 0, 0);
        check_output("load_window", digits_o, 32'h2011_0456);
        check_output("load_pos", 32'(pos_o), 32'h0);

        repeat (40) apply_stimulus(0, 0, 0, 10, 1, 0, 0);

        apply_stimulus(0, 0, 0, 10, 0, 1, 1);
        repeat (2) apply_stimulus(0, 0, 0, 10, 0, 1, 0);
        check_output("right_pos", 32'(pos_o), 32'd9);
        check_output("right_window", digits_o, 32'h8201_1045);
        repeat (6) apply_stimulus(0, 0, 0, 10, 1, 1, 1);

        for (int i = 0; i < 3; i++) apply_stimulus(1, i, i + 1, 3, 0, 0, 0);
        repeat (2) apply_stimulus(0, 0, 0, 3, 0, 0, 0);
        repeat (2) begin
            apply_stimulus(0, 0, 0, 3, 0, 0, 1);
            apply_stimulus(0, 0, 0, 3, 0, 0, 0);
        end
        apply_stimulus(0, 0, 0, 2, 0, 0, 0);
        apply_stimulus(0, 0, 0, 2, 0, 0, 0);
        repeat (3) apply_stimulus(0, 0, 0, 0, 0, 0, 1);
        repeat (8) apply_stimulus(0, 0, 0, 0, 1, 0, 0);

        for (int i = 0; i < ML; i++) apply_stimulus(1, i, load_code[i], 10, 0, 0, 0);
        apply_stimulus(0, 0, 0, 10, 0, 1, 1);
        apply_stimulus(0, 0, 0, 10, 0, 0, 0);
        apply_stimulus(1, 0, 9, 10, 0, 0, 1);
        apply_stimulus(1, 12, 5, 10, 0, 0, 0);
        repeat (2) apply_stimulus(0, 0, 0, 10, 0, 0, 0);
        repeat (3) apply_stimulus(0, 0, 0, 15, 0, 1, 1);

        cur_run = 1'b0;
        cur_len = 10;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 15) == 0) cur_len = int'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) cur_run = ~cur_run;
            apply_stimulus($urandom_range(0, 3) == 0, int'($urandom_range(0, 15)),
                           int'($urandom_range(0, 15)), cur_len, cur_run,
                           $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0);
        end

        for (int i = 0; i < ML; i++) apply_stimulus(1, i, load_code[i], 10, 0, 0, 0);
        for (int i = 0; i < 8 && tcnt_m != 2; i++) apply_stimulus(0, 0, 0, 10, 1, 0, 0);
        check_output("pre_reset_tcnt", 32'(tcnt_m), 32'd2);
        do_reset();
        first_step = 0;
        for (int i = 1; i <= 12; i++) begin
            apply_stimulus(0, 0, 0, 10, 1, 0, 0);
            @(posedge clk);
            #1;
            if (step_o && first_step == 0) first_step = i;
        end
        check_output("first_step_after_reset", 32'(first_step), 32'd4);

        repeat (2) @(negedge clk);
        check_output("scoreboard_drained", 32'(sb.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_code_scroller.md
# shift_code_scroller

Parametrised successor to the fixed 8-digit code shifter: holds a programmable code string of up to MAX_LEN digits and presents a NUM_DIGITS-wide window that scrolls around it, left or right, at a rate set by an internal tick divider or by manual step pulses. It replaces the separate 1 Hz divider plus fixed shifter in front of the per-digit BCD converters and TM1638 driver. Everything runs on the system clock; the divided clock is gone.

## Interface

Parameters:
- NUM_DIGITS, 8, number of displayed digits (window width), ≥1
- MAX_LEN, 16, code buffer depth in digits, ≥NUM_DIGITS not required
- DIG_W, 4, bits per digit
- TICK_DIV, 50_000_000, clk cycles per automatic scroll step, ≥2

Ports:
- clk  in  1  system clock, all logic rising-edge
- rst_n  in  1  asynchronous, active-low reset
- wr_en  in  1  write code digit this cycle
- wr_addr  in  $clog2(MAX_LEN)  code buffer index
- wr_data  in  DIG_W  digit value
- len  in  $clog2(MAX_LEN+1)  active code length; values >MAX_LEN clamp to MAX_LEN
- run  in  1  1 = auto-scroll from tick divider, 0 = paused
- dir  in  1  0 = text moves left (pos increments), 1 = moves right (pos decrements)
- step_req  in  1  single-cycle manual step, honoured only when run=0
- digits_o  out  NUM_DIGITS*DIG_W  window; digit k (k=0 leftmost) at bits [(NUM_DIGITS-k)*DIG_W-1 -: DIG_W]
- pos_o  out  $clog2(MAX_LEN)  current window start index
- step_o  out  1  one-cycle pulse in the cycle pos updates

## Operation

- State: code buffer code[0..MAX_LEN-1], position pos, tick counter tcnt (0..TICK_DIV-1), registered digits_o, step_o.
- Reset (async, rst_n=0): code all 0, pos=0, tcnt=0, digits_o=0, step_o=0, pos_o=0.
- Write: wr_en=1 and wr_addr<MAX_LEN → code[wr_addr]<=wr_data; wr_addr≥MAX_LEN ignored. Writes allowed in any mode.
- Effective length L = min(len, MAX_LEN).
- Tick: run=1 → tcnt increments, wraps TICK_DIV-1→0; wrap cycle is a step event. run=0 → tcnt holds its value (resumes, not restarts).
- Step event = (run=1 and tcnt==TICK_DIV-1) or (run=0 and step_req=1). step_req with run=1 ignored.
- On step event with L≥1: dir=0 → pos<=(pos+1) mod L; dir=1 → pos<=(pos==0)?L-1:pos-1. step_o=1 that next cycle.
- L=0: pos forced to 0, step events ignored (no step_o), digits_o all zero.
- pos≥L (len reduced): pos<=0 next cycle, no step_o; a coincident step event is dropped.
- Window: digits_o[k] = code[(pos+k) mod L] for all k; when L<NUM_DIGITS the string repeats across the window.
- Simultaneous write + step: both take effect in the same cycle.

## Timing

- digits_o and pos_o registered; digits_o at cycle t+1 is computed from code, pos, len as registered at cycle t → 1-cycle latency after any pos change, write, or len change.
- step_o asserted in the cycle pos_o shows the new value; digits_o reflects it one cycle after step_o.
- Auto-step period exactly TICK_DIV cycles while run held 1; first step TICK_DIV cycles after run rises from reset.
- Reset mid-step or mid-write: all state returns to reset values immediately; no partial update survives.
- Modulo arithmetic must close timing at target clock for default parameters (registered output absorbs the index logic).

## Test plan

- NUM_DIGITS=8, MAX_LEN=10, TICK_DIV=4, load code 2,0,1,1,0,4,5,6,7,8, len=10, run=0 → digits_o = 2,0,1,1,0,4,5,6, pos_o=0, no step_o.
- run=1, dir=0 → step_o every 4 cycles; after step 1 window 0,1,1,0,4,5,6,7; after step 3 window 1,0,4,5,6,7,8,2 (wrap); after step 10 pos_o=0.
- run=0, dir=1, one step_req from pos 0 → pos_o=9, window 8,2,0,1,1,0,4,5; step_req with run=1 produces no extra step.
- len=3 with code 1,2,3 → window 1,2,3,1,2,3,1,2; then pos=2, len set to 2 → pos_o=0 next cycle, no step_o; len=0 → window all 0, steps ignored.
- Write code[0]=9 in same cycle as a step from pos 9 (dir=0, len=10) → pos_o=0 and window starts 9 one cycle later; wr_addr=12 has no effect.
- Assert rst_n=0 mid-run with tcnt=2 → all outputs 0 immediately; after release with run=1, first step_o exactly 4 cycles later.
